// File: rtl/button_monitor_if.sv
// Signal bundle between the front-panel button monitor and the bootloader control logic.
// The monitor uses the slave view; the consumer (or a bench) uses the master view.
interface button_monitor_if;
    logic       button_n;
    logic       pressed;
    logic       short_press;
    logic       long_press;
    logic [7:0] press_count;

    modport master (
        output button_n,
        input  pressed,
        input  short_press,
        input  long_press,
        input  press_count
    );

    modport slave (
        input  button_n,
        output pressed,
        output short_press,
        output long_press,
        output press_count
    );
endinterface

// File: rtl/button_monitor.sv
// Front-panel pushbutton reader: synchronise, debounce, classify short/long presses,
// and keep a wrapping count of short presses.
//
// state | meaning
// IDLE  | button released, waiting for a debounced press
// HELD  | button down, hold time below the long-press threshold
// LONG  | long press already reported, waiting for release
module button_monitor #(
    parameter int clock_speed   = 12_500_000,
    parameter int debounce_ms   = 20,
    parameter int long_press_ms = 2000
) (
    input  logic            clock,
    input  logic            reset,
    button_monitor_if.slave bus
);

    localparam int DB   = clock_speed / 1000 * debounce_ms;
    localparam int LP   = clock_speed / 1000 * long_press_ms;
    localparam int DB_W = $clog2(DB + 1);
    localparam int LP_W = $clog2(LP + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB - 1);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LP - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } state_t;

    logic            sync_meta;
    logic            sync_last;
    logic            sync;
    logic [DB_W-1:0] db_cnt;
    logic            pressed_q;

    state_t          state;
    state_t          state_nxt;
    logic [LP_W-1:0] hold_cnt;
    logic [LP_W-1:0] hold_cnt_nxt;
    logic [LP_W-1:0] hold_inc;
    logic            short_q;
    logic            short_nxt;
    logic            long_q;
    logic            long_nxt;
    logic [7:0]      count_q;
    logic [7:0]      count_nxt;

    // Both flops idle at 1 so reset looks like a released button.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b1;
            sync_last <= 1'b1;
        end else begin
            sync_meta <= bus.button_n;
            sync_last <= sync_meta;
        end
    end

    assign sync = ~sync_last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_cnt    <= '0;
            pressed_q <= 1'b0;
        end else if (sync != pressed_q) begin
            if (db_cnt == DB_LAST) begin
                pressed_q <= ~pressed_q;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            short_q  <= short_nxt;
            long_q   <= long_nxt;
            count_q  <= count_nxt;
        end
    end

    // The IDLE->HELD cycle counts as the first held cycle, so the threshold is
    // tested on the incremented value; long_press then lands LP cycles after
    // pressed rises and hold_cnt tops out at LP-1.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        short_nxt    = 1'b0;
        long_nxt     = 1'b0;
        count_nxt    = count_q;
        hold_inc     = hold_cnt + LP_W'(1);

        case (state)
            IDLE: begin
                if (pressed_q) begin
                    state_nxt    = HELD;
                    hold_cnt_nxt = '0;
                end
            end
            HELD: begin
                if (!pressed_q) begin
                    short_nxt = 1'b1;
                    count_nxt = count_q + 8'd1;
                    state_nxt = IDLE;
                end else begin
                    hold_cnt_nxt = hold_inc;
                    if (hold_inc == LP_LAST) begin
                        long_nxt  = 1'b1;
                        state_nxt = LONG;
                    end
                end
            end
            LONG: begin
                if (!pressed_q) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.pressed     = pressed_q;
    assign bus.short_press = short_q;
    assign bus.long_press  = long_q;
    assign bus.press_count = count_q;

endmodule

// File: tb/tb_button_monitor.sv
// Directed bench for button_monitor with DB=20 and LP=100 cycles; expected
// edge numbers are derived from the synchroniser/debounce/FSM latencies.
module tb_button_monitor;

    localparam int CLK_SPEED = 10_000;
    localparam int DEB_MS    = 2;
    localparam int LP_MS     = 10;
    localparam int DB        = 20;
    localparam int LP        = 100;

    logic clock = 1'b0;
    logic reset = 1'b1;

    button_monitor_if bus();

    button_monitor #(
        .clock_speed   (CLK_SPEED),
        .debounce_ms   (DEB_MS),
        .long_press_ms (LP_MS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    int edge_cnt = 0;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    int   rise_cnt   = 0;
    int   rise_edge  = 0;
    int   fall_edge  = 0;
    int   short_evt  = 0;
    int   short_cyc  = 0;
    int   short_edge = 0;
    int   long_evt   = 0;
    int   long_cyc   = 0;
    int   long_edge  = 0;
    int   both_cnt   = 0;
    logic p_prev     = 1'b0;
    logic s_prev     = 1'b0;
    logic l_prev     = 1'b0;

    // Event recorder: edge numbers of pressed transitions and pulse activity.
    always @(negedge clock) begin
        if (bus.pressed === 1'b1 && p_prev === 1'b0) begin
            rise_cnt  <= rise_cnt + 1;
            rise_edge <= edge_cnt;
        end
        if (bus.pressed === 1'b0 && p_prev === 1'b1) fall_edge <= edge_cnt;
        if (bus.short_press === 1'b1) begin
            short_cyc  <= short_cyc + 1;
            short_edge <= edge_cnt;
            if (s_prev !== 1'b1) short_evt <= short_evt + 1;
        end
        if (bus.long_press === 1'b1) begin
            long_cyc  <= long_cyc + 1;
            long_edge <= edge_cnt;
            if (l_prev !== 1'b1) long_evt <= long_evt + 1;
        end
        if (bus.short_press === 1'b1 && bus.long_press === 1'b1) both_cnt <= both_cnt + 1;
        p_prev <= bus.pressed;
        s_prev <= bus.short_press;
        l_prev <= bus.long_press;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic wait_pressed(input logic val, input int max, output bit ok);
        int i;
        i = 0;
        while (bus.pressed !== val && i < max) begin
            step(1);
            i++;
        end
        ok = (bus.pressed === val);
    endtask

    task automatic do_reset();
        bus.button_n = 1'b1;
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(2);
    endtask

    task automatic test_reset();
        int r0, s0, l0;
        bus.button_n = 1'b1;
        reset = 1'b1;
        step(2);
        checks++;
        if ({bus.pressed, bus.short_press, bus.long_press} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {bus.pressed, bus.short_press, bus.long_press});
        end
        checks++;
        if (bus.press_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", bus.press_count);
        end
        reset = 1'b0;
        r0 = rise_cnt; s0 = short_evt; l0 = long_evt;
        step(500);
        checks++;
        if (bus.pressed !== 1'b0 || bus.press_count !== 8'd0) begin
            errors++;
            $display("FAIL idle_state: got pressed=%b count=%0d expected 0/0", bus.pressed, bus.press_count);
        end
        checks++;
        if (rise_cnt - r0 != 0 || short_evt - s0 != 0 || long_evt - l0 != 0) begin
            errors++;
            $display("FAIL idle_events: got rise=%0d short=%0d long=%0d expected 0/0/0",
                     rise_cnt - r0, short_evt - s0, long_evt - l0);
        end
    endtask

    task automatic test_glitch();
        int r0, s0, settle;
        bit ok;
        do_reset();
        r0 = rise_cnt; s0 = short_evt;
        bus.button_n = 1'b0;
        step(15);
        bus.button_n = 1'b1;
        step(40);
        checks++;
        if (bus.pressed !== 1'b0 || rise_cnt != r0) begin
            errors++;
            $display("FAIL glitch_15: got pressed=%b rises=%0d expected 0/0", bus.pressed, rise_cnt - r0);
        end
        for (int i = 0; i < 5; i++) begin
            bus.button_n = 1'b0;
            step(10);
            bus.button_n = 1'b1;
            step(10);
        end
        checks++;
        if (rise_cnt != r0 || short_evt != s0) begin
            errors++;
            $display("FAIL bounce_ignored: got rises=%0d shorts=%0d expected 0/0", rise_cnt - r0, short_evt - s0);
        end
        bus.button_n = 1'b0;
        settle = edge_cnt + 1;
        wait_pressed(1'b1, 100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL settle_timeout: got pressed=%b expected 1", bus.pressed);
        end
        checks++;
        if (rise_edge != settle + DB + 1) begin
            errors++;
            $display("FAIL settle_latency: got %0d expected %0d", rise_edge - settle, DB + 1);
        end
        bus.button_n = 1'b1;
        wait_pressed(1'b0, 100, ok);
        step(5);
    endtask

    task automatic test_short();
        int s0, sc0, l0, r;
        bit ok;
        do_reset();
        s0 = short_evt; sc0 = short_cyc; l0 = long_evt;
        bus.button_n = 1'b0;
        wait_pressed(1'b1, 100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL short_rise_timeout: got pressed=%b expected 1", bus.pressed);
        end
        r = rise_edge;
        step(28);
        bus.button_n = 1'b1;
        wait_pressed(1'b0, 100, ok);
        checks++;
        if (!ok || fall_edge != r + 50) begin
            errors++;
            $display("FAIL short_hold_len: got %0d expected 50", fall_edge - r);
        end
        step(3);
        checks++;
        if (short_evt - s0 != 1 || short_cyc - sc0 != 1) begin
            errors++;
            $display("FAIL short_pulse: got events=%0d cycles=%0d expected 1/1", short_evt - s0, short_cyc - sc0);
        end
        checks++;
        if (short_edge != fall_edge + 1) begin
            errors++;
            $display("FAIL short_latency: got %0d expected 1", short_edge - fall_edge);
        end
        checks++;
        if (long_evt != l0) begin
            errors++;
            $display("FAIL short_no_long: got %0d expected 0", long_evt - l0);
        end
        checks++;
        if (bus.press_count !== 8'd1) begin
            errors++;
            $display("FAIL short_count: got %0d expected 1", bus.press_count);
        end
    endtask

    task automatic test_long();
        int s0, l0, lc0, r;
        bit ok;
        do_reset();
        s0 = short_evt; l0 = long_evt; lc0 = long_cyc;
        bus.button_n = 1'b0;
        wait_pressed(1'b1, 100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL long_rise_timeout: got pressed=%b expected 1", bus.pressed);
        end
        r = rise_edge;
        step(300);
        bus.button_n = 1'b1;
        wait_pressed(1'b0, 100, ok);
        step(3);
        checks++;
        if (long_evt - l0 != 1 || long_cyc - lc0 != 1) begin
            errors++;
            $display("FAIL long_pulse: got events=%0d cycles=%0d expected 1/1", long_evt - l0, long_cyc - lc0);
        end
        checks++;
        if (long_edge != r + LP) begin
            errors++;
            $display("FAIL long_latency: got %0d expected %0d", long_edge - r, LP);
        end
        checks++;
        if (short_evt != s0) begin
            errors++;
            $display("FAIL long_no_short: got %0d expected 0", short_evt - s0);
        end
        checks++;
        if (bus.press_count !== 8'd0) begin
            errors++;
            $display("FAIL long_count: got %0d expected 0", bus.press_count);
        end
    endtask

    task automatic test_wrap();
        int s0, sc0, l0;
        do_reset();
        s0 = short_evt; sc0 = short_cyc; l0 = long_evt;
        for (int i = 1; i <= 257; i++) begin
            bus.button_n = 1'b0;
            step(30);
            bus.button_n = 1'b1;
            step(30);
            if (i == 255) begin
                checks++;
                if (bus.press_count !== 8'd255) begin
                    errors++;
                    $display("FAIL count_255: got %0d expected 255", bus.press_count);
                end
            end
            if (i == 256) begin
                checks++;
                if (bus.press_count !== 8'd0) begin
                    errors++;
                    $display("FAIL count_wrap0: got %0d expected 0", bus.press_count);
                end
            end
        end
        checks++;
        if (bus.press_count !== 8'd1) begin
            errors++;
            $display("FAIL count_wrap1: got %0d expected 1", bus.press_count);
        end
        checks++;
        if (short_evt - s0 != 257 || short_cyc - sc0 != 257) begin
            errors++;
            $display("FAIL wrap_pulses: got events=%0d cycles=%0d expected 257/257", short_evt - s0, short_cyc - sc0);
        end
        checks++;
        if (long_evt != l0) begin
            errors++;
            $display("FAIL wrap_no_long: got %0d expected 0", long_evt - l0);
        end
    endtask

    task automatic test_reset_mid();
        int s0, l0, e;
        bit ok;
        do_reset();
        bus.button_n = 1'b0;
        step(30);
        bus.button_n = 1'b1;
        step(30);
        checks++;
        if (bus.press_count !== 8'd1) begin
            errors++;
            $display("FAIL mid_pre_count: got %0d expected 1", bus.press_count);
        end
        s0 = short_evt; l0 = long_evt;
        bus.button_n = 1'b0;
        wait_pressed(1'b1, 100, ok);
        step(60);
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.pressed, bus.short_press, bus.long_press} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset_flags: got %b expected 000", {bus.pressed, bus.short_press, bus.long_press});
        end
        checks++;
        if (bus.press_count !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset_count: got %0d expected 0", bus.press_count);
        end
        step(3);
        checks++;
        if (short_evt != s0 || long_evt != l0) begin
            errors++;
            $display("FAIL mid_reset_pulse: got short=%0d long=%0d expected 0/0", short_evt - s0, long_evt - l0);
        end
        reset = 1'b0;
        e = edge_cnt;
        wait_pressed(1'b1, 100, ok);
        checks++;
        if (!ok || rise_edge != e + DB + 2) begin
            errors++;
            $display("FAIL mid_rerise: got %0d expected %0d", rise_edge - e, DB + 2);
        end
        step(LP + 10);
        checks++;
        if (long_evt - l0 != 1 || long_edge != rise_edge + LP) begin
            errors++;
            $display("FAIL mid_long: got events=%0d latency=%0d expected 1/%0d",
                     long_evt - l0, long_edge - rise_edge, LP);
        end
        bus.button_n = 1'b1;
        wait_pressed(1'b0, 100, ok);
        step(3);
        checks++;
        if (short_evt != s0 || bus.press_count !== 8'd0) begin
            errors++;
            $display("FAIL mid_release: got shorts=%0d count=%0d expected 0/0", short_evt - s0, bus.press_count);
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL pulse_overlap: got %0d expected 0", both_cnt);
        end
    endtask

    initial begin
        bus.button_n = 1'b1;
        test_reset();
        test_glitch();
        test_short();
        test_long();
        test_wrap();
        test_reset_mid();
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/button_monitor.md
# button_monitor

Front-panel pushbutton reader for the bootloader: the input-side counterpart of the status LED driver. Synchronises the raw active-low button, debounces it, and classifies each press as short or long, emitting single-cycle event pulses for the bootloader control logic (e.g. long press forces bootloader mode, short presses select actions). Also keeps a wrapping count of short presses.

## Interface
- clock_speed, 12_500_000: clock frequency in Hz.
- debounce_ms, 20: required input stability time in ms; DB = clock_speed/1000*debounce_ms cycles, must be ≥ 1.
- long_press_ms, 2000: hold time that qualifies as a long press; LP = clock_speed/1000*long_press_ms cycles, must be > DB.

- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- button_n  input  1  raw button, active-low, asynchronous to clock, bouncy.
- pressed  output  1  debounced button level, 1 = held.
- short_press  output  1  one-cycle pulse: button released before LP cycles of hold.
- long_press  output  1  one-cycle pulse: hold reached LP cycles (button still down).
- press_count  output  8  number of short presses since reset, modulo 256.

## Operation
- Synchroniser: two flops on button_n; both reset to 1 (released). sync = inverted second-flop output (1 = down).
- Debouncer: db_cnt (width $clog2(DB+1)) counts consecutive cycles with sync != pressed; cleared to 0 on any cycle with sync == pressed. When sync != pressed and db_cnt == DB-1, pressed toggles and db_cnt clears. Any bounce shorter than DB cycles leaves pressed unchanged.
- Classifier FSM on pressed, states IDLE, HELD, LONG:
  - IDLE: pressed rising → HELD, hold_cnt cleared to 0.
  - HELD: hold_cnt increments each cycle. pressed falling → short_press=1 for one cycle, press_count+1, → IDLE. Else hold_cnt == LP-1 → long_press=1 for one cycle, → LONG.
  - LONG: hold_cnt frozen; pressed falling → IDLE, no pulse.
- Release and LP threshold in the same cycle: release wins (short_press, no long_press).
- short_press and long_press never both 1; each at most once per press.
- press_count wraps 255 → 0; long presses do not count.
- hold_cnt width $clog2(LP+1), never overflows.

## Timing
- Reset values: pressed=0, short_press=0, long_press=0, press_count=0, FSM=IDLE, db_cnt=0, hold_cnt=0, sync flops=1.
- Reset is asynchronous; asserting it mid-press or mid-debounce immediately returns all outputs to reset values with no pulse. A button still held after reset release is debounced and treated as a new press.
- Latency raw → pressed: button_n stable from edge k gives pressed change at edge k+2+DB-1 (2 synchroniser cycles, DB debounce cycles including the toggle edge).
- short_press asserted the cycle after pressed falls (registered), for exactly one cycle.
- long_press asserted exactly LP cycles after pressed rises, for exactly one cycle.
- Outputs are all registered; no combinational path from button_n.

## Test plan
Parameters for bench: clock_speed=10_000, debounce_ms=2 (DB=20), long_press_ms=10 (LP=100).
- Reset then idle with button_n=1 for 500 cycles → pressed, short_press, long_press, press_count all stay 0.
- button_n pulses low for 15 cycles, then 1 (glitch < DB) → pressed stays 0, no pulses; repeat bouncing 5×10-cycle toggles then steady low → pressed rises exactly DB+1 cycles after final settle edge.
- Clean press held 50 cycles of pressed, then release → one short_press pulse one cycle after pressed falls, press_count=1, long_press never asserted.
- Press held 300 cycles → long_press single pulse 100 cycles after pressed rises, no short_press on release, press_count unchanged.
- 257 clean short presses → press_count reads 1 (wrap), 257 short_press pulses counted.
- Assert reset in the middle of a held press (hold_cnt≈60) with button still down → outputs zero at once, no pulse; after reset release pressed re-rises after DB+2 cycles and a long_press follows LP cycles later.
